fhg_tx_pkt_fifo: RTL and testbench
==================================

# fhg_tx_pkt_fifo

Store-and-forward packet FIFO sitting directly upstream of the 400G TX segmented-AXIS adapter. Accepts the CASPER 1024-bit AXI4-Stream, buffers whole packets, and releases a packet only once its last beat is stored. Released packets stream gap-free, which the DCMAC requires because it cannot tolerate a mid-packet underrun. Oversized, overflowing and (optionally) errored packets are dropped whole, never truncated.

## Interface
- DATA_WIDTH, 1024, bus width in bits; KEEP_WIDTH = DATA_WIDTH/8
- DEPTH, 256, buffer depth in beats, power of 2
- MAX_PKT_BEATS, 64, longest legal packet in beats (8192 B / 128 B)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata / tkeep / tlast / tuser / tvalid  in  1024/128/1/1/1  CASPER TX stream
- s_axis_tready  out  1  0 during rst, else constant 1
- m_axis_tdata / tkeep / tlast / tuser / tvalid  out  1024/128/1/1/1  to adapter
- m_axis_tready  in  1  downstream ready
- tx_pause  in  1  DCMAC almost-full (OR of dcmac_tx_af); blocks packet starts only
- pkt_count  out  log2(DEPTH)+1  committed packets not yet started on m side
- drop_count  out  32  dropped packets, wraps at 2^32
- overflow  out  1  one-cycle pulse per drop

## Operation
- RAM stores {tdata, tkeep, tlast, tuser}. Pointers wr_ptr, wr_start (first beat of the current packet), rd_ptr are log2(DEPTH)+1 bits wide. Full when wr_ptr − rd_ptr == DEPTH.
- Write FSM states: IDLE, FILL, DISCARD.
  - IDLE/FILL: accepted beat written at wr_ptr, wr_ptr++, beat counter++.
  - Beat with tlast: commit. wr_start ← wr_ptr+1, pkt_count++, return to IDLE.
  - Beat arriving while full, or beat number MAX_PKT_BEATS+1 without tlast: drop. wr_ptr ← wr_start, overflow pulse, drop_count++. Go to DISCARD, or stay IDLE if that beat carried tlast.
  - DISCARD: beats ignored until tlast, then IDLE.
- Read FSM states: IDLE, SEND.
  - IDLE → SEND when pkt_count>0 and tx_pause==0. pkt_count-- on that cycle.
  - SEND: beats presented in order. Return to IDLE after the tlast beat handshakes.
  - tx_pause asserted in SEND has no effect until the packet ends.
- Simultaneous commit and read start: pkt_count unchanged.
- m_axis_tvalid never deasserts inside a packet. A 2-entry output skid buffer with prefetch guarantees one beat per cycle while m_axis_tready=1.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, s_axis_tready=0, pkt_count=0, drop_count=0, overflow=0. Both FSMs go to IDLE and all pointers are zeroed.
- rst mid-packet: buffered and in-flight data is lost. m_axis_tvalid=0 at the edge after rst is sampled. No drop is counted.
- Latency: the tlast beat is accepted at edge N. With the read side IDLE, tx_pause=0 and the buffer otherwise empty, the first beat shows m_axis_tvalid=1 after edge N+2.
- Packets back-to-back in the buffer: the next packet's first beat follows the previous tlast beat with zero idle cycles.
- overflow pulses at the edge after the offending beat is sampled.
- m_axis outputs are registered; no combinational path from s_* to m_*.

## Configuration
- FHG_TX_FIFO_DROP_ERR_EN defined: a tlast beat with tuser=1 is treated as a drop (rewind, overflow pulse, drop_count++). m_axis_tuser is then always 0.
- Not defined: tuser is stored and forwarded unchanged on the corresponding m-side beat; errored packets are delivered.

## Test plan
- Single 64-beat packet, tkeep all-ones, last beat tkeep=128'h0000_FFFF, m_axis_tready=1 → after tlast at edge N, 64 contiguous beats from N+2. Data and tkeep bit-exact, tlast only on beat 64, pkt_count 1→0.
- Three 4-beat packets back-to-back, then hold m_axis_tready=0 for 5 cycles mid-packet 2 → pkt_count peaks at 2. Stall holds data stable, no gaps otherwise, 12 beats out in order.
- 65-beat packet without tlast until beat 70, followed by a 2-beat packet → one overflow pulse, drop_count=1. Only the 2-beat packet appears.
- DEPTH=8, m_axis_tready=0, write a 5-beat packet then a 6-beat packet → the second packet is dropped at its 4th beat (full) and the first is intact. Release tready → exactly 5 beats out.
- tx_pause=1 with 2 committed packets → no m_axis_tvalid. Deassert → both packets stream. Assert tx_pause mid-packet 1 → packet 1 completes and packet 2 is held.
- 2-beat packet with tuser=1 on tlast → with FHG_TX_FIFO_DROP_ERR_EN, dropped and drop_count=1; without it, delivered with m_axis_tuser=1 on beat 2.

Source files
------------

// File: rtl/fhg_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO ahead of the 400G segmented-AXIS adapter.
// Optional build macro FHG_TX_FIFO_DROP_ERR_EN drops packets whose tlast beat carries tuser=1.
module fhg_tx_pkt_fifo #(
    parameter int DATA_WIDTH    = 1024,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int DEPTH         = 256,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic                     tx_pause,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [31:0]              drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(MAX_PKT_BEATS + 1);
    localparam int RW = DATA_WIDTH + KEEP_WIDTH + 2;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DISCARD = 2'd2} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rd_state_t;

    logic [RW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] last_mem_r;

    wr_state_t        wr_state_r, wr_state_s;
    logic [PW-1:0]    wr_ptr_r, wr_ptr_s;
    logic [PW-1:0]    wr_start_r, wr_start_s;
    logic [BW-1:0]    beat_cnt_r, beat_cnt_s;
    logic             we_s, commit_s, drop_s;
    logic             ready_r, overflow_r;
    logic [31:0]      drop_count_r;
    logic [PW-1:0]    pkt_count_r;

    rd_state_t        rd_state_r, rd_state_s;
    logic [AW-1:0]    fetch_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             issue_s, start_s, room_s, pop_s, fetch_last_s, pkt_avail_s;
    logic [1:0]       fill_s;
    logic [RW-1:0]    q_r, m_r, sk_r;
    logic             q_valid_r, m_valid_r, sk_valid_r;

    logic             s_beat_s, full_s, oversize_s, err_s, user_in_s;
    logic [RW-1:0]    wdata_s;

`ifdef FHG_TX_FIFO_DROP_ERR_EN
    assign err_s     = s_axis_tlast & s_axis_tuser;
    assign user_in_s = 1'b0;
`else
    assign err_s     = 1'b0;
    assign user_in_s = s_axis_tuser;
`endif

    assign s_beat_s    = s_axis_tvalid & ready_r;
    // Fullness uses the handshake pointer, so beats held in the output stage still occupy space.
    assign full_s      = (wr_ptr_r - rd_ptr_r) == PW'(DEPTH);
    assign oversize_s  = (beat_cnt_r == BW'(MAX_PKT_BEATS));
    assign wdata_s     = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, user_in_s};

    // Write FSM: append beats, commit on tlast, rewind on drop.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_ptr_s   = wr_ptr_r;
        wr_start_s = wr_start_r;
        beat_cnt_s = beat_cnt_r;
        we_s       = 1'b0;
        commit_s   = 1'b0;
        drop_s     = 1'b0;
        case (wr_state_r)
            W_IDLE, W_FILL: begin
                if (s_beat_s) begin
                    if (full_s || oversize_s || err_s) begin
                        drop_s     = 1'b1;
                        wr_ptr_s   = wr_start_r;
                        beat_cnt_s = {BW{1'b0}};
                        wr_state_s = s_axis_tlast ? W_IDLE : W_DISCARD;
                    end else begin
                        we_s     = 1'b1;
                        wr_ptr_s = wr_ptr_r + PW'(1);
                        if (s_axis_tlast) begin
                            commit_s   = 1'b1;
                            wr_start_s = wr_ptr_r + PW'(1);
                            beat_cnt_s = {BW{1'b0}};
                            wr_state_s = W_IDLE;
                        end else begin
                            beat_cnt_s = beat_cnt_r + BW'(1);
                            wr_state_s = W_FILL;
                        end
                    end
                end else begin
                    wr_state_s = wr_state_r;
                end
            end
            W_DISCARD: begin
                if (s_beat_s && s_axis_tlast) begin
                    wr_state_s = W_IDLE;
                end else begin
                    wr_state_s = W_DISCARD;
                end
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write-side registers and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r   <= W_IDLE;
            wr_ptr_r     <= {PW{1'b0}};
            wr_start_r   <= {PW{1'b0}};
            beat_cnt_r   <= {BW{1'b0}};
            ready_r      <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 32'd0;
        end else begin
            wr_state_r   <= wr_state_s;
            wr_ptr_r     <= wr_ptr_s;
            wr_start_r   <= wr_start_s;
            beat_cnt_r   <= beat_cnt_s;
            ready_r      <= 1'b1;
            overflow_r   <= drop_s;
            drop_count_r <= drop_count_r + {31'd0, drop_s};
        end
    end

    // Buffer RAM: write port from the s side, registered read port for prefetch.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_ptr_r[AW-1:0]]      <= wdata_s;
            last_mem_r[wr_ptr_r[AW-1:0]] <= s_axis_tlast;
        end
        if (issue_s) begin
            q_r <= mem_r[fetch_ptr_r];
        end
    end

    assign pop_s        = m_valid_r & m_axis_tready;
    assign fetch_last_s = last_mem_r[fetch_ptr_r];
    assign pkt_avail_s  = (pkt_count_r != {PW{1'b0}});
    assign fill_s       = {1'b0, m_valid_r} + {1'b0, sk_valid_r} + {1'b0, q_valid_r};
    // A new read may issue only if the output pair will still have a free slot when it lands.
    assign room_s       = (fill_s - {1'b0, pop_s}) < 2'd2;

    // Read FSM: a packet is opened only between packets, so tx_pause never splits one.
    always_comb begin
        rd_state_s = rd_state_r;
        issue_s    = 1'b0;
        start_s    = 1'b0;
        case (rd_state_r)
            R_IDLE: begin
                if (pkt_avail_s && !tx_pause && room_s) begin
                    issue_s    = 1'b1;
                    start_s    = 1'b1;
                    rd_state_s = fetch_last_s ? R_IDLE : R_SEND;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_SEND: begin
                if (room_s) begin
                    issue_s    = 1'b1;
                    rd_state_s = fetch_last_s ? R_IDLE : R_SEND;
                end else begin
                    rd_state_s = R_SEND;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read-side pointers, prefetch valid and committed-packet count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r  <= R_IDLE;
            fetch_ptr_r <= {AW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            q_valid_r   <= 1'b0;
            pkt_count_r <= {PW{1'b0}};
        end else begin
            rd_state_r  <= rd_state_s;
            fetch_ptr_r <= fetch_ptr_r + {{(AW-1){1'b0}}, issue_s};
            rd_ptr_r    <= rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
            q_valid_r   <= issue_s;
            case ({commit_s, start_s})
                2'b10:   pkt_count_r <= pkt_count_r + PW'(1);
                2'b01:   pkt_count_r <= pkt_count_r - PW'(1);
                default: pkt_count_r <= pkt_count_r;
            endcase
        end
    end

    // Two-entry output stage: m_r is the presented beat, sk_r absorbs a beat landing during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r        <= {RW{1'b0}};
            m_valid_r  <= 1'b0;
            sk_r       <= {RW{1'b0}};
            sk_valid_r <= 1'b0;
        end else if (!m_valid_r || pop_s) begin
            if (sk_valid_r) begin
                m_r        <= sk_r;
                m_valid_r  <= 1'b1;
                sk_r       <= q_r;
                sk_valid_r <= q_valid_r;
            end else begin
                m_r        <= q_r;
                m_valid_r  <= q_valid_r;
            end
        end else if (q_valid_r) begin
            sk_r       <= q_r;
            sk_valid_r <= 1'b1;
        end
    end

    assign s_axis_tready = ready_r;
    assign m_axis_tdata  = m_r[RW-1 -: DATA_WIDTH];
    assign m_axis_tkeep  = m_r[KEEP_WIDTH+1:2];
    assign m_axis_tlast  = m_r[1];
    assign m_axis_tuser  = m_r[0];
    assign m_axis_tvalid = m_valid_r;
    assign pkt_count     = pkt_count_r;
    assign drop_count    = drop_count_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_fhg_tx_pkt_fifo.sv
// Scoreboard bench for fhg_tx_pkt_fifo: expected beats queued at drive time, popped on m-side handshakes.
module tb_fhg_tx_pkt_fifo;

    localparam int DW = 1024;
    localparam int KW = 128;
    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          tx_pause = 1'b0;
    logic [PW-1:0] pkt_count;
    logic [31:0]   drop_count;
    logic          overflow;

    fhg_tx_pkt_fifo dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .tx_pause(tx_pause), .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    beat_t         sb[$];
    beat_t         mon_e;
    int            n_checks = 0;
    int            n_errors = 0;
    int            nout = 0;
    int            ovf_cnt = 0;
    int            peak = 0;
    int            base = 0;
    int            ob = 0;
    bit            in_pkt = 1'b0;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_d;
    logic [KW-1:0] all1 = {KW{1'b1}};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard compare, gap-free and stall-hold checks.
    always @(negedge clk) begin
        if (rst) begin
            in_pkt    = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (in_pkt) chk("gap", 128'(m_axis_tvalid), 128'(1'b1));
            if (hold_pend) chk("stall_hold", 128'(m_axis_tdata == hold_d), 128'(1'b1));
            if (m_axis_tvalid && m_axis_tready) begin
                chk("sb_nonempty", 128'(sb.size() != 0), 128'(1'b1));
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    for (int c = 0; c < DW / 128; c++)
                        chk("tdata", m_axis_tdata[c*128 +: 128], mon_e.d[c*128 +: 128]);
                    chk("tkeep", m_axis_tkeep, mon_e.k);
                    chk("tlast", 128'(m_axis_tlast), 128'(mon_e.l));
                    chk("tuser", 128'(m_axis_tuser), 128'(mon_e.u));
                end
                in_pkt = !m_axis_tlast;
                nout++;
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold_d    = m_axis_tdata;
            if (overflow) ovf_cnt++;
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int n, input logic [KW-1:0] keep_last, input logic user_last,
                            input bit push, input int drop_at);
        beat_t b;
        for (int i = 1; i <= n; i++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
            b.k = (i == n) ? keep_last : all1;
            b.l = (i == n);
            b.u = (i == n) ? user_last : 1'b0;
            s_axis_tdata  = b.d;
            s_axis_tkeep  = b.k;
            s_axis_tlast  = b.l;
            s_axis_tuser  = b.u;
            s_axis_tvalid = 1'b1;
            if (push) sb.push_back(b);
            @(posedge clk);
            #1;
            if (i == drop_at) chk("ovf_pulse", 128'(overflow), 128'(1'b1));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic wait_nout(input int target, input int limit);
        for (int i = 0; i < limit && nout < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_out", 128'(nout >= target), 128'(1'b1));
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        chk("rst_tdata", m_axis_tdata[127:0], 128'(0));
        chk("rst_tready", 128'(s_axis_tready), 128'(1'b0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_drop_count", 128'(drop_count), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(1'b0));
        rst = 1'b0;
        idle(2);
        chk("tready_up", 128'(s_axis_tready), 128'(1'b1));

        // single 64-beat packet: latency and short last beat
        base = nout;
        send_pkt(64, 128'h0000_FFFF, 1'b0, 1'b1, 0);
        chk("lat_n_cnt", 128'(pkt_count), 128'(1));
        chk("lat_n_vld", 128'(m_axis_tvalid), 128'(1'b0));
        idle(1);
        chk("lat_n1_cnt", 128'(pkt_count), 128'(0));
        chk("lat_n1_vld", 128'(m_axis_tvalid), 128'(1'b0));
        idle(1);
        chk("lat_n2_vld", 128'(m_axis_tvalid), 128'(1'b1));
        drain(200);
        chk("t1_beats", 128'(nout - base), 128'(64));

        // three 4-beat packets, stall mid packet 2
        m_axis_tready = 1'b0;
        peak = 0;
        base = nout;
        repeat (3) send_pkt(4, all1, 1'b0, 1'b1, 0);
        chk("t2_cnt", 128'(pkt_count), 128'(2));
        m_axis_tready = 1'b1;
        wait_nout(base + 6, 50);
        m_axis_tready = 1'b0;
        idle(5);
        m_axis_tready = 1'b1;
        drain(100);
        chk("t2_beats", 128'(nout - base), 128'(12));
        chk("t2_peak", 128'(peak), 128'(2));

        // oversized packet dropped at beat 65, following packet delivered
        base = nout;
        ob = ovf_cnt;
        send_pkt(70, all1, 1'b0, 1'b0, 65);
        send_pkt(2, all1, 1'b0, 1'b1, 0);
        drain(100);
        chk("t3_beats", 128'(nout - base), 128'(2));
        chk("t3_drop_count", 128'(drop_count), 128'(1));
        chk("t3_ovf_pulses", 128'(ovf_cnt - ob), 128'(1));

        // fill to full: 252 beats fit, next packet dropped at its 5th beat
        m_axis_tready = 1'b0;
        base = nout;
        repeat (3) send_pkt(64, all1, 1'b0, 1'b1, 0);
        send_pkt(60, all1, 1'b0, 1'b1, 0);
        send_pkt(6, all1, 1'b0, 1'b0, 5);
        chk("t4_drop_count", 128'(drop_count), 128'(2));
        chk("t4_cnt", 128'(pkt_count), 128'(3));
        m_axis_tready = 1'b1;
        drain(400);
        chk("t4_beats", 128'(nout - base), 128'(252));

        // tx_pause holds packet starts but not an open packet
        tx_pause = 1'b1;
        base = nout;
        send_pkt(8, all1, 1'b0, 1'b1, 0);
        send_pkt(8, all1, 1'b0, 1'b1, 0);
        idle(5);
        chk("t5_pause_vld", 128'(m_axis_tvalid), 128'(1'b0));
        chk("t5_pause_cnt", 128'(pkt_count), 128'(2));
        tx_pause = 1'b0;
        wait_nout(base + 2, 50);
        tx_pause = 1'b1;
        idle(20);
        chk("t5_mid_out", 128'(nout - base), 128'(8));
        chk("t5_mid_vld", 128'(m_axis_tvalid), 128'(1'b0));
        chk("t5_mid_cnt", 128'(pkt_count), 128'(1));
        tx_pause = 1'b0;
        drain(100);
        chk("t5_beats", 128'(nout - base), 128'(16));

        // errored packet (tuser on tlast)
        base = nout;
`ifdef FHG_TX_FIFO_DROP_ERR_EN
        send_pkt(2, all1, 1'b1, 1'b0, 2);
        idle(10);
        chk("t6_drop_count", 128'(drop_count), 128'(3));
        chk("t6_beats", 128'(nout - base), 128'(0));
`else
        send_pkt(2, all1, 1'b1, 1'b1, 0);
        drain(50);
        chk("t6_drop_count", 128'(drop_count), 128'(2));
        chk("t6_beats", 128'(nout - base), 128'(2));
`endif

        // reset with a packet in flight, then normal restart
        m_axis_tready = 1'b0;
        send_pkt(3, all1, 1'b0, 1'b1, 0);
        idle(4);
        chk("t7_pre_vld", 128'(m_axis_tvalid), 128'(1'b1));
        rst = 1'b1;
        sb.delete();
        idle(1);
        chk("t7_rst_vld", 128'(m_axis_tvalid), 128'(1'b0));
        chk("t7_rst_cnt", 128'(pkt_count), 128'(0));
        chk("t7_rst_drop", 128'(drop_count), 128'(0));
        rst = 1'b0;
        m_axis_tready = 1'b1;
        idle(2);
        base = nout;
        send_pkt(2, all1, 1'b0, 1'b1, 0);
        drain(50);
        chk("t7_beats", 128'(nout - base), 128'(2));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
